// File: rtl/nibble_packer.sv
// nibble_packer: assembles consecutive 4-bit nibbles into W-bit words and
// buffers finished words in a small first-word-fall-through FIFO.
//
// Handshake: a word moves downstream on a posedge where out_valid and
// out_ready are both 1. out_valid is 1 exactly when the FIFO holds a word.
// While out_valid is 1 and out_ready is 0, out_data holds its value.
// Upstream has no backpressure, so in_valid=1 always accepts in_data.
module nibble_packer #(
    parameter int NIBBLES_PER_WORD = 4,
    parameter int FIFO_DEPTH       = 4,
    parameter bit MSB_FIRST        = 1'b1,
    localparam int W  = 4 * NIBBLES_PER_WORD,
    localparam int CW = $clog2(NIBBLES_PER_WORD) + 1,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    in_data,
    input  logic          in_valid,
    input  logic          flush,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] nib_count,
    output logic [LW-1:0] fifo_level,
    output logic          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [W-1:0]  asm_word;
    logic [W-1:0]  merged;
    logic [CW-1:0] count;
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf;
    logic          complete;
    logic          do_push;
    logic          full;
    logic          pop;
    logic          write;

    // Assembly register with this cycle's nibble dropped into slot `count`.
    always_comb begin
        merged = asm_word;
        if (in_valid) begin
            for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
                if (count == CW'(k)) begin
                    merged[(MSB_FIRST ? (W - 4 - 4 * k) : (4 * k)) +: 4] = in_data;
                end
            end
        end
    end

    // Push decision: a completed word, or a flush with something to send.
    // A flush on the completing nibble is the same single push.
    always_comb begin
        complete = in_valid && (count == CW'(NIBBLES_PER_WORD - 1));
        do_push  = complete || (flush && ((count != '0) || in_valid));
        full     = (level == LW'(FIFO_DEPTH));
        pop      = (level != '0) && out_ready;
        // When full, the word fits only if the head leaves on the same edge.
        write    = do_push && (!full || pop);
    end

    // Assembly register and nibble counter; any push restarts at slot 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_word <= '0;
            count    <= '0;
        end else if (do_push) begin
            asm_word <= '0;
            count    <= '0;
        end else if (in_valid) begin
            asm_word <= merged;
            count    <= count + CW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written, pointers gate reads.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= merged;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (write) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({write, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow: a word was dropped because nothing could make room.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (do_push && !write) begin
            ovf <= 1'b1;
        end
    end

    // Head of FIFO drives the output directly; zero while empty.
    always_comb begin
        out_valid  = (level != '0);
        out_data   = out_valid ? mem[rd_ptr] : '0;
        nib_count  = count;
        fifo_level = level;
        overflow   = ovf;
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: an MSB-first and an LSB-first instance share
// one stimulus stream and are compared every cycle against a queue model.
module tb_nibble_packer;

    localparam int N  = 4;
    localparam int FD = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [15:0] m_data, l_data;
    logic        m_valid, l_valid;
    logic [2:0]  m_cnt, l_cnt;
    logic [2:0]  m_lvl, l_lvl;
    logic        m_ovf, l_ovf;

    int checks = 0;
    int errors = 0;

    // Model state: nibbles of the partial word, buffered words, sticky flag.
    logic [3:0]  nibs[$];
    logic [15:0] qm[$];
    logic [15:0] ql[$];
    logic        mod_ovf;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [3:0]  d;
        logic        f;
        logic        r;
        int          e_cnt;
        int          e_lvl;
        logic        e_vld;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[$];

    nibble_packer #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(FD), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .flush(flush),
        .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
        .nib_count(m_cnt), .fifo_level(m_lvl), .overflow(m_ovf)
    );

    nibble_packer #(.NIBBLES_PER_WORD(N), .FIFO_DEPTH(FD), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .flush(flush),
        .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .nib_count(l_cnt), .fifo_level(l_lvl), .overflow(l_ovf)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] build(input logic [3:0] n[$], input bit msb);
        logic [15:0] w;
        w = '0;
        foreach (n[i]) begin
            if (msb) w[15 - 4 * i -: 4] = n[i];
            else     w[4 * i +: 4]      = n[i];
        end
        return w;
    endfunction

    // Reference behaviour for one posedge, using the inputs held across it.
    task automatic model_step();
        bit do_pop, do_push;
        if (!rst) begin
            nibs.delete();
            qm.delete();
            ql.delete();
            mod_ovf = 1'b0;
        end else begin
            do_pop = (qm.size() > 0) && out_ready;
            if (in_valid) nibs.push_back(in_data);
            do_push = (nibs.size() == N) || (flush && nibs.size() > 0);
            if (do_pop) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (do_push) begin
                if (qm.size() == FD) begin
                    mod_ovf = 1'b1;
                end else begin
                    qm.push_back(build(nibs, 1'b1));
                    ql.push_back(build(nibs, 1'b0));
                end
                nibs.delete();
            end
        end
    endtask

    task automatic compare_model();
        chk("msb_data",  32'(m_data),  32'(qm.size() > 0 ? qm[0] : 16'h0));
        chk("lsb_data",  32'(l_data),  32'(ql.size() > 0 ? ql[0] : 16'h0));
        chk("msb_valid", 32'(m_valid), 32'(qm.size() > 0));
        chk("lsb_valid", 32'(l_valid), 32'(ql.size() > 0));
        chk("msb_cnt",   32'(m_cnt),   32'(nibs.size()));
        chk("lsb_cnt",   32'(l_cnt),   32'(nibs.size()));
        chk("msb_lvl",   32'(m_lvl),   32'(qm.size()));
        chk("lsb_lvl",   32'(l_lvl),   32'(ql.size()));
        chk("msb_ovf",   32'(m_ovf),   32'(mod_ovf));
        chk("lsb_ovf",   32'(l_ovf),   32'(mod_ovf));
    endtask

    // Drive one cycle's inputs, step the model at the edge, check at negedge.
    task automatic cycle(input logic r_n, input logic v, input logic [3:0] d,
                         input logic f, input logic rdy);
        rst       = r_n;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic nib(input logic [3:0] d, input logic rdy);
        cycle(1'b1, 1'b1, d, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b1, 1'b0, 4'h0, 1'b0, rdy);
    endtask

    function automatic vec_t mk(input logic rst_n, input logic v, input logic [3:0] d,
                                input logic f, input logic r, input int e_cnt,
                                input int e_lvl, input logic e_vld, input logic [15:0] e_data);
        vec_t x;
        x.rst_n = rst_n; x.v = v; x.d = d; x.f = f; x.r = r;
        x.e_cnt = e_cnt; x.e_lvl = e_lvl; x.e_vld = e_vld; x.e_data = e_data;
        return x;
    endfunction

    initial begin
        mod_ovf   = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Basic word 1234 after a two-cycle reset, then gapped ABCD.
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'h1, 0, 1, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'h2, 0, 1, 2, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'h3, 0, 1, 3, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'h4, 0, 1, 0, 1, 1, 16'h1234));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'hA, 0, 1, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'hB, 0, 1, 2, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 2, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 2, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'hC, 0, 1, 3, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 4'hD, 0, 1, 0, 1, 1, 16'hABCD));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 0, 16'h0000));

        @(negedge clk);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].r);
            chk($sformatf("vec%0d_cnt", i),  32'(m_cnt),   32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_lvl", i),  32'(m_lvl),   32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d_vld", i),  32'(m_valid), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d_data", i), 32'(m_data),  32'(vecs[i].e_data));
        end

        // LSB-first packing of 1,2,3,4.
        do_reset();
        nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0); nib(4'h4, 0);
        chk("lsb_4321", 32'(l_data), 32'h4321);
        chk("msb_1234", 32'(m_data), 32'h1234);

        // Overflow: five words with no drain, fifth dropped.
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            for (int k = 0; k < N; k++) nib(4'(w), 0);
        end
        chk("ovf_level", 32'(m_lvl), 32'd4);
        chk("ovf_flag",  32'(m_ovf), 32'd1);
        for (int w = 1; w <= 4; w++) begin
            chk($sformatf("drain%0d", w), 32'(m_data), 32'(16'h1111 * w));
            idle(1);
        end
        chk("drain_empty", 32'(m_valid), 32'd0);
        chk("ovf_sticky",  32'(m_ovf),   32'd1);

        // Flush: partial word, flush on a nibble, flush with nothing held.
        do_reset();
        nib(4'h7, 0); nib(4'h8, 0);
        cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("flush_data", 32'(m_data), 32'h7800);
        chk("flush_lsb",  32'(l_data), 32'h0087);
        chk("flush_cnt",  32'(m_cnt),  32'd0);
        cycle(1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
        chk("flush_nib_lvl", 32'(m_lvl), 32'd2);
        cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("flush_noop_lvl", 32'(m_lvl), 32'd2);
        idle(1);
        chk("flush_second", 32'(m_data), 32'h9000);
        // Flush coinciding with the completing nibble is one push.
        nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0);
        cycle(1'b1, 1'b1, 4'h4, 1'b1, 1'b0);
        chk("flush_full_lvl", 32'(m_lvl), 32'd2);
        idle(1);
        chk("flush_full_data", 32'(m_data), 32'h1234);
        idle(1);

        // Full FIFO with simultaneous pop and completing push.
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < N; k++) nib(4'(w + 8), 0);
        end
        nib(4'hE, 0); nib(4'hE, 0); nib(4'hE, 0);
        nib(4'hE, 1);
        chk("pp_level", 32'(m_lvl),  32'd4);
        chk("pp_ovf",   32'(m_ovf),  32'd0);
        chk("pp_head",  32'(m_data), 32'hAAAA);
        for (int w = 0; w < 4; w++) idle(1);
        chk("pp_empty", 32'(m_lvl), 32'd0);

        // Reset mid-word with a non-empty FIFO discards everything.
        do_reset();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < N; k++) nib(4'h3, 0);
        end
        nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0);
        chk("pre_rst_lvl", 32'(m_lvl), 32'd2);
        chk("pre_rst_cnt", 32'(m_cnt), 32'd3);
        do_reset();
        chk("rst_cnt", 32'(m_cnt),   32'd0);
        chk("rst_lvl", 32'(m_lvl),   32'd0);
        chk("rst_vld", 32'(m_valid), 32'd0);
        chk("rst_ovf", 32'(m_ovf),   32'd0);
        nib(4'h5, 1); nib(4'h6, 1); nib(4'h7, 1); nib(4'h8, 1);
        chk("post_rst_msb", 32'(m_data), 32'h5678);
        chk("post_rst_lsb", 32'(l_data), 32'h8765);
        idle(1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the 4-bit shift-register stage.
- Collects consecutive valid 4-bit nibbles from the shift-register output into NIBBLES_PER_WORD-nibble words.
- Buffers completed words in a small first-word-fall-through FIFO.
- Hands words to the next stage over a valid/ready interface. Supports partial-word flush and reports overflow.

Parameters:
- NIBBLES_PER_WORD, 4, nibbles per output word; word width W = 4*NIBBLES_PER_WORD; must be >= 2.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2.
- MSB_FIRST, 1, 1: first nibble lands in the top nibble of the word; 0: first nibble lands in bits [3:0].

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- in_data  input  4  nibble from the shift-register output.
- in_valid  input  1  in_data is valid this cycle and is accepted unconditionally (no backpressure upstream).
- flush  input  1  push the current partial word, zero-padded.
- out_data  output  W  FIFO head word; 0 when the FIFO is empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data.
- nib_count  output  $clog2(NIBBLES_PER_WORD)+1  nibbles held in the partial word.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset: a posedge with rst==0 has priority over every other input. It clears the assembly register, nib_count, FIFO pointers, fifo_level and overflow. Next cycle: out_valid=0, out_data=0.
- Nibble accept: on a posedge with in_valid=1, in_data is written at slot nib_count.
  - MSB_FIRST=1: slot k occupies bits [W-1-4k : W-4-4k].
  - MSB_FIRST=0: slot k occupies bits [4k+3 : 4k].
  - nib_count increments.
- Word completion: in_valid=1 with nib_count==NIBBLES_PER_WORD-1.
  - The full word (assembly plus this nibble) is pushed on the same edge.
  - nib_count returns to 0 and the assembly register clears.
- Latency: the word appears on out_data with out_valid=1 in the cycle after the accepting edge (FWFT, registered pointers).
- Flush: on a posedge with flush=1 and (nib_count>0 or in_valid=1), the word including any nibble accepted this edge is pushed. Unfilled slots are 0. nib_count returns to 0.
  - If that nibble already completes the word, it is a single normal push, never two.
  - flush=1 with nib_count==0 and in_valid=0 is a no-op.
- Pop: occurs on a posedge with out_valid && out_ready. While out_valid && !out_ready, out_data is held stable.
- Push when full: a push with fifo_level==FIFO_DEPTH and no pop on the same edge drops the word and sets overflow. overflow stays 1 until reset.
  - The assembly state still resets, so nib_count becomes 0.
- Push and pop on the same edge while full: both succeed. No overflow; fifo_level is unchanged.
- Push and pop on the same edge otherwise: both succeed and fifo_level is unchanged. Push alone adds 1; pop alone subtracts 1.
- Empty FIFO: out_ready is ignored and no pop occurs.
- Pointers wrap modulo FIFO_DEPTH. Ordering is strictly first-in first-out.
- Reset mid-word or with a non-empty FIFO: all partial and buffered data is discarded. The first nibble after reset goes into slot 0.

Test Plan:
- Defaults; rst=0 for 2 cycles, then nibbles 1,2,3,4 on consecutive cycles with out_ready=1 -> nib_count steps 1,2,3,0; one cycle after the 4th edge, out_data=16'h1234 with out_valid=1 for exactly one cycle; fifo_level returns to 0.
- Gapped input A,-,B,-,-,C,D (in_valid low on "-"), out_ready=1 -> exactly one word 16'hABCD. Repeat with MSB_FIRST=0 and nibbles 1,2,3,4 -> 16'h4321.
- out_ready=0; push five words 16'h1111..16'h5555 -> fifo_level=4, overflow=1, 16'h5555 dropped. Then out_ready=1 -> drain yields 1111,2222,3333,4444 in order; overflow stays 1.
- Nibbles 7,8 then flush=1 with in_valid=0 -> word 16'h7800, nib_count=0. Then nibble 9 with flush=1 -> 16'h9000. Then flush=1 alone -> no push.
- FIFO full (level 4), out_ready=1 on the same edge a 4th nibble completes a word -> head pops, new word enters, fifo_level stays 4, overflow stays 0.
- Three nibbles accepted and fifo_level=2, then rst=0 for one cycle -> next cycle nib_count=0, fifo_level=0, out_valid=0, overflow=0. Nibbles 5,6,7,8 afterwards -> 16'h5678.
